// File: rtl/freq_period_meter.sv
// Measures the period of an asynchronous divided clock in clk cycles and reports
// lock once LOCK_CNT consecutive identical measurements have been seen.
module freq_period_meter #(
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             lost,
  output logic             change
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_e;

  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise, tmo_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] stored_q, stored_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       match_q, match_d, match_nx;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;
  logic             change_q, change_d;

  assign rise    = s2_q & ~s3_q;
  assign tmo_hit = (cnt_q == TMO);
  // A rise landing on the saturated count is clamped rather than wrapped.
  assign meas     = tmo_hit ? TMO : cnt_q + CNT_W'(1);
  assign match_nx = ((match_q != 4'd0) && (meas == stored_q)) ? match_q + 4'd1 : 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = rise ? '0 : (tmo_hit ? cnt_q : cnt_q + CNT_W'(1));
    match_d  = match_q;
    stored_d = stored_q;
    period_d = period_q;
    locked_d = locked_q;
    lost_d   = lost_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ACQUIRE;
        end else if (tmo_hit) begin
          state_d = LOST;
          lost_d  = 1'b1;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          match_d  = match_nx;
          stored_d = meas;
          if (match_nx >= LOCK_N) begin
            state_d  = LOCKED;
            period_d = meas;
            locked_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = LOST;
          lost_d  = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (meas != period_q) begin
            state_d  = ACQUIRE;
            period_d = '0;
            locked_d = 1'b0;
            match_d  = 4'd1;
            stored_d = meas;
          end
        end else if (tmo_hit) begin
          state_d  = LOST;
          period_d = '0;
          locked_d = 1'b0;
          lost_d   = 1'b1;
        end
      end
      LOST: begin
        // First rise after loss only restarts timing.
        if (rise) begin
          state_d = ACQUIRE;
          lost_d  = 1'b0;
          match_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    change_d = (period_d != period_q) || (locked_d != locked_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      match_q  <= '0;
      stored_q <= '0;
      period_q <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= clk_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      stored_q <= stored_d;
      period_q <= period_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      change_q <= change_d;
    end
  end

  assign period = period_q;
  assign locked = locked_q;
  assign lost   = lost_q;
  assign change = change_q;

endmodule

// File: tb/tb_freq_period_meter.sv
// Randomized and scenario-driven bench for freq_period_meter against an
// event-level model built on rise timestamps.
module tb_freq_period_meter;

  localparam int CNT_W    = 10;
  localparam int LOCK_CNT = 2;
  localparam int TIMEOUT  = 1023;

  logic             clk;
  logic             rst;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic             locked;
  logic             lost;
  logic             change;

  freq_period_meter #(
    .CNT_W   (CNT_W),
    .LOCK_CNT(LOCK_CNT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clk_in(clk_in),
    .period(period),
    .locked(locked),
    .lost  (lost),
    .change(change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: sampled input history, rise timestamps, lock bookkeeping.
  int       k;
  int       last;
  bit [2:0] hv;
  bit       timing;
  bit       m_lost, m_locked, e_change;
  int       m_period, prev_m, run;

  task automatic model_step(input bit v, input bit r);
    bit rise;
    int m;
    int old_p;
    bit old_l;
    old_p = m_period;
    old_l = m_locked;
    k++;
    if (r) begin
      hv = '0; last = k; timing = 0; m_lost = 0; m_locked = 0;
      m_period = 0; prev_m = 0; run = 0; e_change = 0;
      return;
    end
    rise = hv[1] && !hv[2];
    hv = {hv[1:0], v};
    if (rise) begin
      if (!timing) begin
        timing = 1; m_lost = 0; run = 0;
      end else begin
        m = k - last;
        if (m_locked) begin
          if (m != m_period) begin
            m_locked = 0; m_period = 0; run = 1; prev_m = m;
          end
        end else begin
          if (run > 0 && m == prev_m) run++;
          else begin run = 1; prev_m = m; end
          if (run >= LOCK_CNT) begin
            m_locked = 1; m_period = m;
          end
        end
      end
      last = k;
    end else if (!m_lost && (k - last) == TIMEOUT + 1) begin
      m_lost = 1; timing = 0; m_locked = 0; m_period = 0;
    end
    e_change = (m_period != old_p) || (m_locked != old_l);
  endtask

  int n_chg;
  int n_lock;

  // One clk cycle: v is the level sampled at the next edge; g wiggles clk_in
  // between edges without affecting the sampled level.
  task automatic cyc(input bit v, input bit g, input bit r);
    #1 clk_in = g ? ~v : v;
    #5 begin clk_in = v; rst = r; end
    @(posedge clk);
    #1;
    model_step(v, r);
    check("period", 32'(period), 32'(m_period));
    check("locked", 32'(locked), 32'(m_locked));
    check("lost",   32'(lost),   32'(m_lost));
    check("change", 32'(change), 32'(e_change));
    if (change) n_chg++;
    if (locked) n_lock++;
  endtask

  task automatic run_period(input int p, input int h, input int n, input bit gl);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++)
        cyc(j < h, gl && ($urandom_range(0, 3) == 0), 1'b0);
  endtask

  task automatic hold(input bit v, input int n, input bit toggling);
    for (int i = 0; i < n; i++) cyc(v, toggling, 1'b0);
  endtask

  initial begin
    int p, h, n;
    k = 0; last = 0; hv = '0; timing = 0; m_lost = 0; m_locked = 0;
    m_period = 0; prev_m = 0; run = 0; e_change = 0;
    clk_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    check("reset_period", 32'(period), 32'd0);

    // clk/6 acquisition
    n_chg = 0;
    run_period(6, 3, 10, 1'b0);
    check("div6_period", 32'(period), 32'd6);
    check("div6_locked", 32'(locked), 32'd1);
    check("div6_pulses", 32'(n_chg), 32'd1);

    // switch to clk/10: unlock then relock
    n_chg = 0;
    run_period(10, 5, 8, 1'b0);
    check("div10_period", 32'(period), 32'd10);
    check("div10_pulses", 32'(n_chg), 32'd2);

    // clk/4 then loss of input, then recovery
    run_period(4, 2, 10, 1'b0);
    check("div4_period", 32'(period), 32'd4);
    n_chg = 0;
    hold(1'b0, 1100, 1'b0);
    check("loss_lost", 32'(lost), 32'd1);
    check("loss_period", 32'(period), 32'd0);
    check("loss_pulses", 32'(n_chg), 32'd1);
    n_chg = 0;
    run_period(4, 2, 10, 1'b0);
    check("recov_lost", 32'(lost), 32'd0);
    check("recov_period", 32'(period), 32'd4);
    check("recov_pulses", 32'(n_chg), 32'd1);

    // single glitched period while locked at 6
    run_period(6, 3, 8, 1'b0);
    n_chg = 0;
    run_period(7, 3, 1, 1'b0);
    run_period(6, 3, 5, 1'b0);
    check("glitch_period", 32'(period), 32'd6);
    check("glitch_pulses", 32'(n_chg), 32'd2);

    // reset pulse while locked at 8
    run_period(8, 4, 6, 1'b0);
    check("div8_period", 32'(period), 32'd8);
    n_chg = 0;
    cyc(1'b0, 1'b0, 1'b1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_change", 32'(change), 32'd0);
    run_period(8, 4, 6, 1'b0);
    check("rst_relock", 32'(period), 32'd8);

    // clk-rate toggling: never a sampled rise
    cyc(1'b1, 1'b0, 1'b1);
    n_lock = 0;
    hold(1'b1, 1100, 1'b1);
    check("fast_lost", 32'(lost), 32'd1);
    check("fast_nolock", 32'(n_lock), 32'd0);

    // randomized segments
    for (int s = 0; s < 60; s++) begin
      p = $urandom_range(2, 20);
      h = $urandom_range(1, p - 1);
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) cyc(1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 7) == 0) run_period(p + $urandom_range(1, 3), h, 1, 1'b1);
      run_period(p, h, n, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
